// File: rtl/alu_nibble_seq.sv
// Sequences an 8-bit ADD/SUB/AND/OR/XOR through an external 4-bit ALU, low nibble then high nibble.
// Optional macro ALU_NIBBLE_SEQ_BYPASS_EN lets a new request enter straight from DONE.
module alu_nibble_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [2:0] in_op,
  input  logic       in_cin,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  output logic       alu_CarryIN,
  output logic       alu_opCodeA,
  output logic       alu_opCodeB,
  output logic       alu_opCodeC,
  input  logic [3:0] alu_Y,
  input  logic       alu_CarryOUT,
  input  logic       alu_overflow,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_y,
  output logic       out_cout,
  output logic       out_ovf,
  output logic       out_zero,
  output logic       out_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic op_supported(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b100, 3'b101, 3'b110: op_supported = 1'b1;
      default:                                op_supported = 1'b0;
    endcase
  endfunction

  function automatic logic op_arith(input logic [2:0] op);
    op_arith = (op[2:1] == 2'b00);
  endfunction

  logic [1:0] state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [2:0] op_q, op_d;
  logic       cin_q, cin_d, carry_lo_q, carry_lo_d;
  logic       cout_q, cout_d, ovf_q, ovf_d, err_q, err_d;
  logic       accept_s;

  // Handshake: only IDLE (and DONE when bypassing with the result being consumed) takes requests.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
`ifdef ALU_NIBBLE_SEQ_BYPASS_EN
      S_DONE: in_ready = out_ready;
`else
      S_DONE: in_ready = 1'b0;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  assign accept_s = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cin_d      = cin_q;
    y_d        = y_q;
    carry_lo_d = carry_lo_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    if (accept_s) begin
      a_d   = in_a;
      b_d   = in_b;
      op_d  = in_op;
      cin_d = in_cin;
      err_d = ~op_supported(in_op);
    end else begin
      err_d = err_q;
    end
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LO: begin
        y_d[3:0]   = op_supported(op_q) ? alu_Y : 4'h0;
        carry_lo_d = alu_CarryOUT;
        state_d    = S_HI;
      end
      S_HI: begin
        // Logic ops and unsupported ops never report carry or overflow.
        y_d[7:4] = op_supported(op_q) ? alu_Y : 4'h0;
        cout_d   = (op_supported(op_q) && op_arith(op_q)) ? alu_CarryOUT : 1'b0;
        ovf_d    = (op_supported(op_q) && op_arith(op_q)) ? alu_overflow : 1'b0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = accept_s ? S_LO : S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive: active only while a nibble is being computed.
  always_comb begin
    alu_A       = 4'h0;
    alu_B       = 4'h0;
    alu_CarryIN = 1'b0;
    alu_opCodeA = 1'b0;
    alu_opCodeB = 1'b0;
    alu_opCodeC = 1'b0;
    case (state_q)
      S_LO: begin
        alu_A       = a_q[3:0];
        alu_B       = b_q[3:0];
        alu_CarryIN = op_arith(op_q) ? cin_q : 1'b0;
        {alu_opCodeA, alu_opCodeB, alu_opCodeC} = op_q;
      end
      S_HI: begin
        alu_A       = a_q[7:4];
        alu_B       = b_q[7:4];
        alu_CarryIN = op_arith(op_q) ? carry_lo_q : 1'b0;
        {alu_opCodeA, alu_opCodeB, alu_opCodeC} = op_q;
      end
      default: begin
        alu_A       = 4'h0;
        alu_B       = 4'h0;
        alu_CarryIN = 1'b0;
        {alu_opCodeA, alu_opCodeB, alu_opCodeC} = 3'b000;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      op_q       <= 3'b000;
      cin_q      <= 1'b0;
      y_q        <= 8'h00;
      carry_lo_q <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cin_q      <= cin_d;
      y_q        <= y_d;
      carry_lo_q <= carry_lo_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out_y     = y_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_err   = err_q;
  assign out_zero  = (state_q == S_DONE) && (y_q == 8'h00);

endmodule
